pid_ctrl_gen: RTL and testbench

Parametrised successor to the e-bike assist PID. It computes the motor drive magnitude from the signed torque/cadence error. Integrator and derivative terms update on a decimated tick. Compared with the previous generation it adds:
- configurable widths, gain shifts and derivative history depth;
- a reset on the output register;
- a rising-edge slew limiter with immediate fall;
- tick and saturation status outputs.
It sits between the error computation and the brushless drive PWM.

---
 rtl/pid_ctrl_gen_if.sv | 23 ++
 rtl/pid_ctrl_gen.sv | 125 ++++++++++++
 tb/tb_pid_ctrl_gen.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pid_ctrl_gen_if.sv
// pid_ctrl_gen_if: error/control inputs and drive/status outputs
// of the e-bike assist PID controller.
interface pid_ctrl_gen_if #(
  parameter int ERR_W = 13,
  parameter int OUT_W = 12
);
  logic signed [ERR_W-1:0] error;
  logic                    not_pedaling;
  logic                    slew_en;
  logic [OUT_W-1:0]        drv_mag;
  logic                    dec_tick;
  logic                    sat_flag;

  modport master (
    output error, not_pedaling, slew_en,
    input  drv_mag, dec_tick, sat_flag
  );

  modport slave (
    input  error, not_pedaling, slew_en,
    output drv_mag, dec_tick, sat_flag
  );
endinterface

// File: rtl/pid_ctrl_gen.sv
// pid_ctrl_gen: parametrised assist PID with decimated I/D terms,
// clamped sum, rise slew limiter and saturation status.
module pid_ctrl_gen #(
  parameter int ERR_W     = 13,
  parameter int OUT_W     = 12,
  parameter int INT_W     = 18,
  parameter int I_SHIFT   = 5,
  parameter int D_SAT_W   = 9,
  parameter int D_SHIFT   = 1,
  parameter int D_DEPTH   = 3,
  parameter int DEC_W     = 20,
  parameter bit FAST_SIM  = 1'b0,
  parameter int SLEW_STEP = 16
) (
  input logic         clk,
  input logic         rst_n,
  pid_ctrl_gen_if.slave io
);
  localparam int N  = FAST_SIM ? 15 : DEC_W;
  localparam int SW = OUT_W + 2;
  localparam int DW = D_SAT_W + D_SHIFT;

  localparam logic signed [ERR_W-1:0] DMAX =
    ERR_W'((1 << (D_SAT_W-1)) - 1);
  localparam logic signed [ERR_W-1:0] DMIN = ~DMAX;

  logic [N-1:0]            cnt;
  logic                    tick;
  logic signed [INT_W-1:0] integ;
  logic signed [INT_W-1:0] isum;
  logic [OUT_W-1:0]        i_term;
  logic signed [ERR_W-1:0] hist [D_DEPTH];
  logic signed [ERR_W-1:0] diff;
  logic signed [D_SAT_W-1:0] dsat;
  logic signed [DW-1:0]    d_term;
  logic [SW-1:0]           psum;
  logic                    over;
  logic [OUT_W-1:0]        target;
  logic [OUT_W:0]          stepw;
  logic [OUT_W-1:0]        drv_nxt;
  logic [OUT_W-1:0]        drv_q;
  logic                    sat_q;

  assign tick        = &cnt;
  assign io.dec_tick = tick;
  assign io.drv_mag  = drv_q;
  assign io.sat_flag = sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + N'(1);
  end

  assign isum = integ +
    {{(INT_W-ERR_W){io.error[ERR_W-1]}}, io.error};

  // pin high on positive overflow, floor at zero otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ <= '0;
    end else if (io.not_pedaling) begin
      integ <= '0;
    end else if (tick) begin
      if (integ[INT_W-2] && isum[INT_W-1])
        integ <= {1'b0, {(INT_W-1){1'b1}}};
      else if (isum[INT_W-1])
        integ <= '0;
      else
        integ <= isum;
    end
  end

  assign i_term = integ[INT_W-2:I_SHIFT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D_DEPTH; i++) hist[i] <= '0;
    end else if (tick) begin
      hist[0] <= io.error;
      for (int i = 1; i < D_DEPTH; i++) hist[i] <= hist[i-1];
    end
  end

  assign diff = io.error - hist[D_DEPTH-1];

  always_comb begin
    dsat = diff[D_SAT_W-1:0];
    if (diff > DMAX)      dsat = DMAX[D_SAT_W-1:0];
    else if (diff < DMIN) dsat = DMIN[D_SAT_W-1:0];
  end

  assign d_term = DW'(dsat) <<< D_SHIFT;

  assign psum = {{(SW-DW){d_term[DW-1]}}, d_term}
              + {{(SW-ERR_W){io.error[ERR_W-1]}}, io.error}
              + {{(SW-OUT_W){1'b0}}, i_term};

  assign over = !psum[SW-1] && psum[OUT_W];

  always_comb begin
    target = psum[OUT_W-1:0];
    if (io.not_pedaling || psum[SW-1]) target = '0;
    else if (over)                     target = '1;
  end

  // rises are rate-limited, falls take effect at once
  assign stepw = {1'b0, drv_q} + (OUT_W+1)'(SLEW_STEP);

  always_comb begin
    drv_nxt = target;
    if (io.slew_en && (target > drv_q) &&
        (stepw < {1'b0, target}))
      drv_nxt = stepw[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_q <= '0;
      sat_q <= 1'b0;
    end else begin
      drv_q <= drv_nxt;
      sat_q <= over && !io.not_pedaling;
    end
  end
endmodule

// File: tb/tb_pid_ctrl_gen.sv
// tb_pid_ctrl_gen: directed scenarios plus randomized error streams
// checked against an arithmetic model of the assist PID.
module tb_pid_ctrl_gen;
  localparam int ERR_W = 13;
  localparam int OUT_W = 12;
  localparam int DEC_W = 6;
  localparam int TPER  = 1 << DEC_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int n_chk = 0;
  int n_err = 0;
  int e_in  = 0;

  int m_integ, m_drv, m_cyc;
  bit m_sat;
  int m_hist[$];

  pid_ctrl_gen_if #(.ERR_W(ERR_W), .OUT_W(OUT_W)) io ();

  pid_ctrl_gen #(.DEC_W(DEC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  function automatic int wrap(input int v, input int w);
    int m;
    int r;
    m = 1 << w;
    r = v & (m - 1);
    if (r >= (m >> 1)) r -= m;
    return r;
  endfunction

  task automatic set_err(input int v);
    e_in     = wrap(v, ERR_W);
    io.error = ERR_W'(v);
  endtask

  task automatic m_reset();
    m_integ = 0;
    m_drv   = 0;
    m_sat   = 0;
    m_cyc   = 0;
    m_hist  = {};
    repeat (3) m_hist.push_back(0);
  endtask

  // one clock edge of the controller, from its arithmetic rules
  task automatic m_step();
    int  e, df, d, it, s, tgt, sm;
    bit  tick, np;
    e    = e_in;
    np   = io.not_pedaling;
    tick = (m_cyc % TPER) == TPER - 1;
    df   = wrap(e - m_hist[0], ERR_W);
    if (df > 255)  df = 255;
    if (df < -256) df = -256;
    d    = df * 2;
    it   = m_integ / 32;
    s    = wrap(d + e + it, OUT_W + 2);
    if (np || s < 0)  tgt = 0;
    else if (s >= 4096) tgt = 4095;
    else tgt = s;
    m_sat = (s >= 4096) && !np;
    if (!io.slew_en || tgt <= m_drv) m_drv = tgt;
    else m_drv = (m_drv + 16 < tgt) ? m_drv + 16 : tgt;
    if (np) begin
      m_integ = 0;
    end else if (tick) begin
      sm = m_integ + e;
      if (sm > 131071) m_integ = 131071;
      else if (sm < 0) m_integ = 0;
      else m_integ = sm;
    end
    if (tick) begin
      m_hist.push_back(e);
      void'(m_hist.pop_front());
    end
    m_cyc++;
  endtask

  task automatic cycle();
    @(posedge clk);
    m_step();
    @(negedge clk);
    chk("drv", io.drv_mag, m_drv);
    chk("sat", io.sat_flag, m_sat);
    chk("tick", io.dec_tick, (m_cyc % TPER) == TPER - 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_drv", io.drv_mag, 0);
    chk("rst_sat", io.sat_flag, 0);
    chk("rst_tick", io.dec_tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  initial begin
    int mode;
    io.not_pedaling = 1'b0;
    io.slew_en      = 1'b0;
    set_err(255);
    m_reset();
    #2;
    do_reset();

    set_err(100);
    cycle();
    chk("t1_drv", io.drv_mag, 300);

    do_reset();
    io.slew_en = 1'b1;
    set_err(100);
    cycle();
    chk("slew_first", io.drv_mag, 16);
    repeat (18) cycle();
    chk("slew_last", io.drv_mag, 300);
    set_err(0);
    cycle();
    chk("slew_fall", io.drv_mag, 0);
    io.slew_en = 1'b0;

    do_reset();
    set_err(32);
    repeat (10 * TPER + 1) cycle();
    chk("int_ten_ticks", io.drv_mag, 42);

    do_reset();
    set_err(-200);
    repeat (100) cycle();
    chk("neg_drv", io.drv_mag, 0);
    chk("neg_sat", io.sat_flag, 0);

    do_reset();
    set_err(4095);
    cycle();
    chk("full_drv", io.drv_mag, 4095);
    chk("full_sat", io.sat_flag, 1);
    repeat (34 * TPER) cycle();
    set_err(0);
    cycle();
    chk("int_pinned", io.drv_mag, 3583);

    do_reset();
    set_err(1000);
    repeat (2 * TPER - 1) cycle();
    io.not_pedaling = 1'b1;
    cycle();
    chk("np_drv", io.drv_mag, 0);
    chk("np_sat", io.sat_flag, 0);
    io.not_pedaling = 1'b0;
    set_err(0);
    cycle();
    chk("np_integ", io.drv_mag, 0);

    for (int seg = 0; seg < 8; seg++) begin
      if (seg == 0 || seg == 4) do_reset();
      mode       = $urandom_range(2);
      io.slew_en = $urandom_range(1);
      for (int k = 0; k < 600; k++) begin
        case (mode)
          0:       set_err($urandom_range(8191));
          1:       set_err($urandom_range(4095, 2000));
          default: set_err(int'($urandom_range(100)) - 50);
        endcase
        io.not_pedaling = ($urandom_range(19) == 0);
        if ($urandom_range(15) == 0) io.slew_en = !io.slew_en;
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
